// File: rtl/ext_int_ctrl.sv
// External interrupt controller: synchronized sources, lowest-index priority, and a claim/complete handshake.
// Define EXT_INT_EDGE_TRIGGER_EN to build per-source edge triggering (TRIGGER register); otherwise all sources are level.
module ext_int_ctrl #(
  parameter int NUM_SRC = 16
) (
  input  logic               clk,
  input  logic               rst_sync,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_wr,
  input  logic               reg_rd,
  input  logic [1:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               meip,
  output logic [26:0]        custom_int_code
);

  typedef enum logic {IDLE, CLAIMED} state_t;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_TRIGGER = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;

  state_t             state_q, state_d;
  logic [4:0]         in_service_id_q, in_service_id_d;
  logic [NUM_SRC-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NUM_SRC-1:0] pending_q, pending_d, enable_q, enable_d;
  logic [31:0]        reg_rdata_q, reg_rdata_d;
  logic [NUM_SRC-1:0] edge_mode, rise, eligible, clr;
  logic [31:0]        trigger_rd;
  logic [4:0]         win_id;
  logic               claim_ok, complete_ok;
  logic               unused_wdata;

`ifdef EXT_INT_EDGE_TRIGGER_EN
  logic [NUM_SRC-1:0] s3_q, s3_d, trigger_q, trigger_d;

  always_comb begin
    s3_d      = s2_q;
    trigger_d = trigger_q;
    if (reg_wr && reg_addr == ADDR_TRIGGER) trigger_d = reg_wdata[NUM_SRC-1:0];
    edge_mode  = trigger_q;
    rise       = s2_q & ~s3_q;
    trigger_rd = 32'(trigger_q);
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      s3_q      <= '0;
      trigger_q <= '0;
    end else begin
      s3_q      <= s3_d;
      trigger_q <= trigger_d;
    end
  end
`else
  always_comb begin
    edge_mode  = '0;
    rise       = '0;
    trigger_rd = '0;
  end
`endif

  assign unused_wdata = ^reg_wdata;

  // The in-service source is masked so it cannot win again until completed.
  always_comb begin
    eligible = pending_q & enable_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_service_id_q == 5'(i + 1)) eligible[i] = 1'b0;
    end
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 5'(i + 1);
    end
  end

  always_comb begin
    s1_d = irq_src;
    s2_d = s1_q;

    claim_ok    = reg_rd && reg_addr == ADDR_CLAIM && state_q == IDLE && win_id != '0;
    complete_ok = reg_wr && reg_addr == ADDR_CLAIM && state_q == CLAIMED &&
                  reg_wdata[4:0] == in_service_id_q;

    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = claim_ok && win_id == 5'(i + 1);
    end
    // Edge set has priority over a claim clear in the same cycle.
    pending_d = (edge_mode & ((pending_q & ~clr) | rise)) | (~edge_mode & s2_q);

    enable_d = enable_q;
    if (reg_wr && reg_addr == ADDR_ENABLE) enable_d = reg_wdata[NUM_SRC-1:0];

    reg_rdata_d = reg_rdata_q;
    if (reg_rd) begin
      case (reg_addr)
        ADDR_PENDING: reg_rdata_d = 32'(pending_q);
        ADDR_ENABLE:  reg_rdata_d = 32'(enable_q);
        ADDR_TRIGGER: reg_rdata_d = trigger_rd;
        default:      reg_rdata_d = (state_q == IDLE) ? 32'(win_id) : 32'd0;
      endcase
    end

    state_d         = state_q;
    in_service_id_d = in_service_id_q;
    if (claim_ok) begin
      state_d         = CLAIMED;
      in_service_id_d = win_id;
    end else if (complete_ok) begin
      state_d         = IDLE;
      in_service_id_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q         <= IDLE;
      in_service_id_q <= '0;
      s1_q            <= '0;
      s2_q            <= '0;
      pending_q       <= '0;
      enable_q        <= '0;
      reg_rdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      in_service_id_q <= in_service_id_d;
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      pending_q       <= pending_d;
      enable_q        <= enable_d;
      reg_rdata_q     <= reg_rdata_d;
    end
  end

  assign reg_rdata       = reg_rdata_q;
  assign meip            = (state_q == IDLE) && (win_id != '0);
  assign custom_int_code = (state_q == IDLE) ? 27'(win_id) : 27'd0;

endmodule

// File: tb/tb_ext_int_ctrl.sv
module tb_ext_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic [15:0] irq_src;
  logic        reg_wr, reg_rd;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        meip;
  logic [26:0] custom_int_code;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ext_int_ctrl #(.NUM_SRC(16)) dut (
    .clk(clk), .rst_sync(rst_sync), .irq_src(irq_src),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .meip(meip), .custom_int_code(custom_int_code)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick(1);
    reg_wr = 1'b0; reg_wdata = '0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    tick(1);
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic test_reset();
    rst_sync = 1'b1; irq_src = '0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    tick(2);
    rst_sync = 1'b0;
    tests++; if (reg_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %0h exp 0", reg_rdata); end
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL reset_meip got %0b exp 0", meip); end
    tests++; if (custom_int_code !== 27'd0) begin fails++; $display("FAIL reset_code got %0h exp 0", custom_int_code); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    reg_write(2'd1, 32'h0001);
    irq_src[0] = 1'b1;
    tick(2);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL level_early_meip got %0b exp 0", meip); end
    tick(1);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL level_meip got %0b exp 1", meip); end
    tests++; if (custom_int_code !== 27'd1) begin fails++; $display("FAIL level_code got %0h exp 1", custom_int_code); end
    reg_read(2'd3, d);
    tests++; if (d !== 32'd1) begin fails++; $display("FAIL level_claim got %0h exp 1", d); end
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL level_claimed_meip got %0b exp 0", meip); end
    reg_write(2'd3, 32'd1);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL level_complete_meip got %0b exp 1", meip); end
    tests++; if (custom_int_code !== 27'd1) begin fails++; $display("FAIL level_complete_code got %0h exp 1", custom_int_code); end
  endtask

  task automatic test_misuse();
    logic [31:0] d;
    reg_read(2'd3, d);
    tests++; if (d !== 32'd1) begin fails++; $display("FAIL misuse_claim got %0h exp 1", d); end
    reg_write(2'd3, 32'd2);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL misuse_badcpl_meip got %0b exp 0", meip); end
    tests++; if (custom_int_code !== 27'd0) begin fails++; $display("FAIL misuse_badcpl_code got %0h exp 0", custom_int_code); end
    reg_read(2'd3, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL misuse_reclaim got %0h exp 0", d); end
    reg_write(2'd3, 32'd1);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL misuse_goodcpl_meip got %0b exp 1", meip); end
    irq_src = '0;
    tick(3);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL level_drop_meip got %0b exp 0", meip); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    reg_write(2'd1, 32'hFFFF);
    irq_src[5] = 1'b1; irq_src[2] = 1'b1;
    tick(3);
    tests++; if (custom_int_code !== 27'd3) begin fails++; $display("FAIL prio_code got %0h exp 3", custom_int_code); end
    reg_read(2'd3, d);
    tests++; if (d !== 32'd3) begin fails++; $display("FAIL prio_claim got %0h exp 3", d); end
    irq_src[2] = 1'b0;
    tick(3);
    tests++; if (custom_int_code !== 27'd0) begin fails++; $display("FAIL prio_claimed_code got %0h exp 0", custom_int_code); end
    reg_write(2'd3, 32'd3);
    tests++; if (custom_int_code !== 27'd6) begin fails++; $display("FAIL prio_next_code got %0h exp 6", custom_int_code); end
    irq_src = '0;
    tick(3);
  endtask

  task automatic test_masked();
    logic [31:0] d;
    reg_write(2'd1, 32'h0);
    irq_src = 16'hFFFF;
    tick(3);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL masked_meip got %0b exp 0", meip); end
    reg_read(2'd3, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL masked_claim got %0h exp 0", d); end
    reg_read(2'd0, d);
    tests++; if (d !== 32'hFFFF) begin fails++; $display("FAIL masked_pending got %0h exp ffff", d); end
    reg_write(2'd0, 32'h0);
    reg_read(2'd0, d);
    tests++; if (d !== 32'hFFFF) begin fails++; $display("FAIL pending_ro got %0h exp ffff", d); end
    irq_src = '0;
    tick(3);
  endtask

  task automatic test_rd_wr_same_cycle();
    reg_write(2'd1, 32'h00A5);
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = 2'd1; reg_wdata = 32'hFFFF_1234;
    tick(1);
    reg_rd = 1'b0; reg_wr = 1'b0;
    tests++; if (reg_rdata !== 32'h00A5) begin fails++; $display("FAIL rdwr_old got %0h exp a5", reg_rdata); end
    reg_rd = 1'b1; reg_addr = 2'd1;
    tick(1);
    reg_rd = 1'b0;
    tests++; if (reg_rdata !== 32'h1234) begin fails++; $display("FAIL rdwr_new got %0h exp 1234", reg_rdata); end
  endtask

`ifdef EXT_INT_EDGE_TRIGGER_EN
  task automatic test_edge();
    logic [31:0] d;
    reg_write(2'd2, 32'h0010);
    reg_write(2'd1, 32'h0010);
    reg_read(2'd2, d);
    tests++; if (d !== 32'h10) begin fails++; $display("FAIL edge_trigger_rd got %0h exp 10", d); end
    irq_src[4] = 1'b1; tick(1); irq_src[4] = 1'b0;
    tick(3);
    reg_read(2'd0, d);
    tests++; if (d !== 32'h10) begin fails++; $display("FAIL edge_pending got %0h exp 10", d); end
    tests++; if (custom_int_code !== 27'd5) begin fails++; $display("FAIL edge_code got %0h exp 5", custom_int_code); end
    reg_read(2'd3, d);
    tests++; if (d !== 32'd5) begin fails++; $display("FAIL edge_claim got %0h exp 5", d); end
    reg_read(2'd0, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL edge_cleared got %0h exp 0", d); end
    irq_src[4] = 1'b1; tick(1); irq_src[4] = 1'b0;
    tick(3);
    reg_read(2'd0, d);
    tests++; if (d !== 32'h10) begin fails++; $display("FAIL edge_repend got %0h exp 10", d); end
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL edge_claimed_meip got %0b exp 0", meip); end
    reg_write(2'd3, 32'd5);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL edge_after_cpl_meip got %0b exp 1", meip); end
    reg_read(2'd3, d);
    reg_write(2'd3, 32'd5);
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL edge_final_meip got %0b exp 0", meip); end
  endtask
`else
  task automatic test_edge();
    logic [31:0] d;
    reg_write(2'd2, 32'h0010);
    reg_read(2'd2, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL trigger_absent got %0h exp 0", d); end
  endtask
`endif

  task automatic test_reset_mid_service();
    logic [31:0] d;
    reg_write(2'd1, 32'h0001);
    irq_src[0] = 1'b1;
    tick(3);
    reg_read(2'd3, d);
    tests++; if (d !== 32'd1) begin fails++; $display("FAIL rst_claim got %0h exp 1", d); end
    rst_sync = 1'b1; tick(1); rst_sync = 1'b0;
    tests++; if (meip !== 1'b0) begin fails++; $display("FAIL rst_meip got %0b exp 0", meip); end
    tests++; if (custom_int_code !== 27'd0) begin fails++; $display("FAIL rst_code got %0h exp 0", custom_int_code); end
    tests++; if (reg_rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata got %0h exp 0", reg_rdata); end
    reg_read(2'd1, d);
    tests++; if (d !== 32'd0) begin fails++; $display("FAIL rst_enable got %0h exp 0", d); end
    reg_write(2'd1, 32'h0001);
    tick(3);
    tests++; if (meip !== 1'b1) begin fails++; $display("FAIL rst_idle_meip got %0b exp 1", meip); end
    irq_src = '0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_misuse();
    test_priority();
    test_masked();
    test_rd_wr_same_cycle();
    test_edge();
    test_reset_mid_service();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ext_int_ctrl.md
# ext_int_ctrl

External interrupt controller that gathers up to `NUM_SRC` peripheral interrupt lines and exposes their state through a small register port. It drives the machine external-interrupt pending bit (`meip`) into the `mip` CSR and supplies `custom_int_code` to the core's trap/exception controller. The trap controller forms `mcause` as `{custom_int_code, 4'b0}`. Lowest-index source has priority; one interrupt is in service at a time, using a claim/complete handshake.

## Interface
Parameters:
- `NUM_SRC`, 16: number of interrupt sources, 1..31; source i carries ID i+1, ID 0 = "none".

Ports:
- `clk`  in  1  core clock.
- `rst_sync`  in  1  synchronous, active-high reset.
- `irq_src`  in  NUM_SRC  raw interrupt lines; may be asynchronous.
- `reg_wr`  in  1  register write strobe, single cycle.
- `reg_rd`  in  1  register read strobe, single cycle.
- `reg_addr`  in  2  0 PENDING (RO), 1 ENABLE (RW), 2 TRIGGER (RW), 3 CLAIM/COMPLETE.
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data, registered.
- `meip`  out  1  to `mip.meip`.
- `custom_int_code`  out  27  zero-extended ID of the winning source; 0 when none.

## Operation
- Synchronizer: each `irq_src` bit passes through a 2-flop synchronizer (`s1`, `s2`) plus a history flop `s3`.
- Pending, edge mode (TRIGGER bit = 1): `pending[i]` sets on `s2 & ~s3`. It clears when source i is claimed. If a set and a clear occur in the same cycle, set wins.
- Pending, level mode (TRIGGER bit = 0): `pending[i] = s2[i]`, registered. Claiming does not clear it.
- Eligibility: `eligible = pending & enable`. A source in service is masked from `eligible`.
- Winner: lowest set index in `eligible`; `win_id = index+1`; 0 if `eligible` is empty.
- The FSM has two states, IDLE and CLAIMED. It holds `in_service_id` (5 bits).
  - IDLE: `meip = (win_id != 0)`; `custom_int_code = win_id`.
  - Read of CLAIM in IDLE: return `win_id` in `reg_rdata[4:0]`.
    - If `win_id != 0`: `in_service_id <= win_id`, clear the edge-mode pending bit, go to CLAIMED.
    - If `win_id == 0`: return 0 and stay in IDLE.
  - CLAIMED: `meip = 0`; `custom_int_code = 0`.
  - Read of CLAIM in CLAIMED: returns 0 and has no side effect.
  - Write of COMPLETE with `wdata[4:0] == in_service_id`: go to IDLE, `in_service_id <= 0`. A mismatched ID is ignored.
  - Write of COMPLETE in IDLE: ignored.
- Register access:
  - Reads of PENDING, ENABLE and TRIGGER return `NUM_SRC` bits, zero-padded to 32.
  - Writes to ENABLE and TRIGGER take bits `[NUM_SRC-1:0]`.
  - Writes to PENDING are ignored.
  - `reg_rd` and `reg_wr` asserted together: the write is performed and the read returns the pre-write value.
- Disabling a pending source in ENABLE removes it from arbitration. It does not clear `pending`.

## Timing
- Reset values: `reg_rdata = 0`, `meip = 0`, `custom_int_code = 0`. Also `pending`, `enable`, `TRIGGER` (all level), `in_service_id` and the synchronizers are 0, and the FSM is in IDLE.
- Reset mid-CLAIMED returns to IDLE with everything cleared.
- `irq_src` rising before posedge k:
  - `s2` is high after posedge k+1.
  - `pending` is high after posedge k+2.
  - `meip` and `custom_int_code` are valid after k+2; they are combinational from the registers.
- Read strobe at posedge t: `reg_rdata` is valid after t and holds until the next read.
- Claim side effects take effect at posedge t: `meip` drops after t.
- COMPLETE write at posedge t: arbitration resumes after t. `meip` may reassert in that same cycle.
- In edge mode, a new edge on an in-service source during CLAIMED re-pends it. It becomes eligible after complete.

## Configuration
- `EXT_INT_EDGE_TRIGGER_EN` defined: the TRIGGER register exists and per-source edge/level selection works as above.
- `EXT_INT_EDGE_TRIGGER_EN` undefined: all sources are level mode. TRIGGER reads 0 and writes are ignored. The edge-detect logic and `s3` are not built.

## Test plan
- Level path: set ENABLE=0x0001, hold `irq_src[0]`=1 → `meip`=1 and `custom_int_code`=1 by the third clock edge; claim read returns 1 and `meip`=0; complete write 1 with the line still high → `meip`=1 again.
- Priority: ENABLE=0xFFFF, raise sources 5 and 2 together → `custom_int_code`=3; claim returns 3; complete 3 → `custom_int_code`=6.
- Edge mode (macro on): TRIGGER=0x0010, ENABLE=0x0010, 1-cycle pulse on source 4 → PENDING reads 0x10, claim returns 5, PENDING reads 0; a second pulse while CLAIMED → PENDING reads 0x10 and `meip` stays 0 until complete 5.
- Handshake misuse: in CLAIMED with ID 1, complete with ID 2 → state unchanged, `meip`=0; claim read → returns 0.
- Empty and masked: ENABLE=0 with all sources high → `meip`=0, claim returns 0, PENDING reads 0xFFFF.
- Reset mid-service: assert `rst_sync` in CLAIMED → all outputs 0 and ENABLE reads 0 next cycle.
